// File: rtl/data_ram_write_arbiter.sv
// data_ram_write_arbiter
//
// Shares the single write port of the MiniAlu data RAM between the ALU
// writeback path and a host/debug loader. ALU writes normally win. A
// starvation counter forces a host grant once the host has been passed
// over MAX_WAIT times in a row, stalling the ALU for that one cycle.
// Every RAM write signal leaves the block registered, so an accepted write
// shows up on the RAM port one cycle after acceptance.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   iAluWe      ALU writeback request this cycle
//   iAluAddr    ALU write address
//   iAluData    ALU write data
//   oAluStall   combinational; ALU holds IP/decode and re-presents its write
//   iHostReq    host write request, level, held until acknowledged
//   iHostAddr   host write address, stable while iHostReq is high
//   iHostData   host write data, stable while iHostReq is high
//   oHostAck    registered one-cycle pulse, host write accepted
//   oRamWe      registered RAM write enable
//   oRamAddr    registered RAM write address
//   oRamData    registered RAM write data
//   oForcedCnt  registered count of forced host grants, saturates at 255

module data_ram_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iAluWe,
    input  logic [ADDR_WIDTH-1:0] iAluAddr,
    input  logic [DATA_WIDTH-1:0] iAluData,
    output logic                  oAluStall,
    input  logic                  iHostReq,
    input  logic [ADDR_WIDTH-1:0] iHostAddr,
    input  logic [DATA_WIDTH-1:0] iHostData,
    output logic                  oHostAck,
    output logic                  oRamWe,
    output logic [ADDR_WIDTH-1:0] oRamAddr,
    output logic [DATA_WIDTH-1:0] oRamData,
    output logic [7:0]            oForcedCnt
);

    localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } stateT;

    stateT      state;
    stateT      nextState;
    logic [3:0] waitCnt;
    logic [3:0] nextCnt;
    logic       acceptAlu;
    logic       acceptHost;
    logic       forcedHit;

    // Arbitration decision for the current cycle. At most one of acceptAlu
    // and acceptHost is set. A dropped host request while waiting is a
    // protocol violation: the wait is abandoned and the ALU proceeds as if
    // nothing had been pending. The ACK state deliberately ignores iHostReq
    // so a host that is still holding its request one cycle after the grant
    // is not granted twice.
    always_comb begin
        nextState  = state;
        nextCnt    = waitCnt;
        acceptAlu  = 1'b0;
        acceptHost = 1'b0;
        forcedHit  = 1'b0;
        oAluStall  = 1'b0;
        case (state)
            IDLE: begin
                if (iHostReq && !iAluWe) begin
                    acceptHost = 1'b1;
                    nextState  = ACK;
                end else if (iHostReq) begin
                    acceptAlu = 1'b1;
                    nextCnt   = 4'd1;
                    nextState = WAIT;
                end else begin
                    acceptAlu = iAluWe;
                end
            end
            WAIT: begin
                if (!iHostReq) begin
                    acceptAlu = iAluWe;
                    nextCnt   = 4'd0;
                    nextState = IDLE;
                end else if (!iAluWe) begin
                    acceptHost = 1'b1;
                    nextCnt    = 4'd0;
                    nextState  = ACK;
                end else if (waitCnt < MaxWaitCnt) begin
                    acceptAlu = 1'b1;
                    nextCnt   = waitCnt + 4'd1;
                end else begin
                    oAluStall  = 1'b1;
                    acceptHost = 1'b1;
                    forcedHit  = 1'b1;
                    nextCnt    = 4'd0;
                    nextState  = ACK;
                end
            end
            ACK: begin
                acceptAlu = iAluWe;
                nextState = IDLE;
            end
            default: begin
                nextCnt   = 4'd0;
                nextState = IDLE;
            end
        endcase
    end

    // State, starvation counter and the registered RAM port. Address and
    // data only load when a write is accepted so the RAM bus holds its last
    // value on idle cycles. Reset discards any pending host request without
    // acknowledging it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            oRamWe     <= 1'b0;
            oRamAddr   <= '0;
            oRamData   <= '0;
            oHostAck   <= 1'b0;
            oForcedCnt <= 8'd0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextCnt;
            oRamWe   <= acceptAlu | acceptHost;
            oHostAck <= acceptHost;
            if (acceptHost) begin
                oRamAddr <= iHostAddr;
                oRamData <= iHostData;
            end else if (acceptAlu) begin
                oRamAddr <= iAluAddr;
                oRamData <= iAluData;
            end
            if (forcedHit && (oForcedCnt != 8'hFF)) begin
                oForcedCnt <= oForcedCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_ram_write_arbiter.sv
// tb_data_ram_write_arbiter
//
// Scoreboard bench for data_ram_write_arbiter. The driver applies inputs on
// the falling edge, steps a reference model that tracks how long the host
// has been passed over, and queues the write the RAM should see after the
// next rising edge. A monitor pops the queue whenever the DUT drives a
// write and otherwise checks that the RAM bus is idle and holding.

module tb_data_ram_write_arbiter;

    localparam int DW      = 16;
    localparam int AW      = 4;
    localparam int MAXWAIT = 4;

    logic          clk;
    logic          rst_n;
    logic          iAluWe;
    logic [AW-1:0] iAluAddr;
    logic [DW-1:0] iAluData;
    logic          oAluStall;
    logic          iHostReq;
    logic [AW-1:0] iHostAddr;
    logic [DW-1:0] iHostData;
    logic          oHostAck;
    logic          oRamWe;
    logic [AW-1:0] oRamAddr;
    logic [DW-1:0] oRamData;
    logic [7:0]    oForcedCnt;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ack;
    } wrT;

    wrT            expQ[$];
    int            total = 0;
    int            bad = 0;
    bit            monitorEn = 0;
    int            blocked = 0;
    bit            cooldown = 0;
    int            expForced = 0;
    bit            hostGranted = 0;
    logic [AW-1:0] lastAddr = '0;
    logic [DW-1:0] lastData = '0;

    data_ram_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT(MAXWAIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iAluWe(iAluWe),
        .iAluAddr(iAluAddr),
        .iAluData(iAluData),
        .oAluStall(oAluStall),
        .iHostReq(iHostReq),
        .iHostAddr(iHostAddr),
        .iHostData(iHostData),
        .oHostAck(oHostAck),
        .oRamWe(oRamWe),
        .oRamAddr(oRamAddr),
        .oRamData(oRamData),
        .oForcedCnt(oForcedCnt)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. The model works from the rules directly: a host
    // that was granted last cycle is ignored this cycle, otherwise the host
    // wins when the ALU is quiet or when it has been passed over MAXWAIT
    // times in a row; an absent host request clears the starvation history.
    task automatic applyStimulus(input logic aWe, input logic [AW-1:0] aAddr, input logic [DW-1:0] aData,
                                 input logic hReq, input logic [AW-1:0] hAddr, input logic [DW-1:0] hData);
        bit expStall;
        wrT w;
        @(negedge clk);
        iAluWe    = aWe;
        iAluAddr  = aAddr;
        iAluData  = aData;
        iHostReq  = hReq;
        iHostAddr = hAddr;
        iHostData = hData;
        expStall    = 0;
        hostGranted = 0;
        if (cooldown) begin
            cooldown = 0;
            if (aWe) begin
                w = '{addr: aAddr, data: aData, ack: 1'b0};
                expQ.push_back(w);
            end
        end else if (hReq) begin
            if (aWe && blocked < MAXWAIT) begin
                w = '{addr: aAddr, data: aData, ack: 1'b0};
                expQ.push_back(w);
                blocked++;
            end else begin
                if (aWe) begin
                    expStall = 1;
                    if (expForced < 255) expForced++;
                end
                w = '{addr: hAddr, data: hData, ack: 1'b1};
                expQ.push_back(w);
                blocked     = 0;
                cooldown    = 1;
                hostGranted = 1;
            end
        end else begin
            blocked = 0;
            if (aWe) begin
                w = '{addr: aAddr, data: aData, ack: 1'b0};
                expQ.push_back(w);
            end
        end
        #1;
        checkOutput("aluStall", 32'(oAluStall), 32'(expStall));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Hold reset for n cycles with random inputs, checking everything stays
    // cleared, then release on a falling edge with quiet inputs.
    task automatic doReset(input int n);
        monitorEn = 0;
        rst_n     = 1'b0;
        expQ.delete();
        blocked   = 0;
        cooldown  = 0;
        expForced = 0;
        lastAddr  = '0;
        lastData  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            iAluWe    = 1'($urandom);
            iAluAddr  = AW'($urandom);
            iAluData  = DW'($urandom);
            iHostReq  = 1'($urandom);
            iHostAddr = AW'($urandom);
            iHostData = DW'($urandom);
            #1;
            checkOutput("rstRamWe", 32'(oRamWe), 32'd0);
            checkOutput("rstRamAddr", 32'(oRamAddr), 32'd0);
            checkOutput("rstRamData", 32'(oRamData), 32'd0);
            checkOutput("rstHostAck", 32'(oHostAck), 32'd0);
            checkOutput("rstForcedCnt", 32'(oForcedCnt), 32'd0);
            checkOutput("rstStall", 32'(oAluStall), 32'd0);
        end
        @(negedge clk);
        iAluWe   = 1'b0;
        iHostReq = 1'b0;
        rst_n    = 1'b1;
        monitorEn = 1;
    endtask

    // Monitor: shortly after each rising edge, pop the expected write when
    // the DUT presents one; on idle cycles the bus must hold its last value
    // and the queue must already be empty since latency is exactly one.
    initial begin
        wrT w;
        forever begin
            @(posedge clk);
            #1;
            if (monitorEn) begin
                if (oRamWe) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedWrite", 32'(oRamWe), 32'd0);
                    end else begin
                        w = expQ.pop_front();
                        checkOutput("ramAddr", 32'(oRamAddr), 32'(w.addr));
                        checkOutput("ramData", 32'(oRamData), 32'(w.data));
                        checkOutput("hostAck", 32'(oHostAck), 32'(w.ack));
                        lastAddr = w.addr;
                        lastData = w.data;
                    end
                end else begin
                    checkOutput("missingWrite", 32'(expQ.size()), 32'd0);
                    expQ.delete();
                    checkOutput("idleAck", 32'(oHostAck), 32'd0);
                    checkOutput("holdAddr", 32'(oRamAddr), 32'(lastAddr));
                    checkOutput("holdData", 32'(oRamData), 32'(lastData));
                end
                checkOutput("forcedCnt", 32'(oForcedCnt), 32'(expForced));
            end
        end
    end

    // Directed scenarios first, then a long randomized run with a host that
    // holds its request until granted and occasionally aborts.
    initial begin
        bit            hostActive;
        logic [AW-1:0] hA;
        logic [DW-1:0] hD;
        rst_n     = 1'b0;
        iAluWe    = 1'b0;
        iAluAddr  = '0;
        iAluData  = '0;
        iHostReq  = 1'b0;
        iHostAddr = '0;
        iHostData = '0;
        doReset(4);

        applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, '0, '0);
        idleCycles(2);

        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 16'hBEEF);
        idleCycles(2);

        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 16'(i), 1'b1, 4'd7, 16'h00AA);
        applyStimulus(1'b1, 4'd5, 16'd5, 1'b0, '0, '0);
        idleCycles(1);
        checkOutput("forcedDirected", 32'(oForcedCnt), 32'd1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1, 4'(i), 16'(16'h0100 + i));
        idleCycles(2);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i), 16'(16'h0200 + i), 1'b1, 4'd9, 16'h0099);
        applyStimulus(1'b1, 4'd4, 16'h0204, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i), 16'(16'h0300 + i), !hostGranted, 4'd10, 16'h00CC);
        idleCycles(2);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i), 16'(16'h0400 + i), 1'b1, 4'd11, 16'h00DD);
        doReset(2);
        idleCycles(4);
        checkOutput("forcedAfterReset", 32'(oForcedCnt), 32'd0);

        hostActive = 0;
        hA = '0;
        hD = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hostActive && $urandom_range(0, 99) < 25) begin
                hostActive = 1;
                hA = AW'($urandom);
                hD = DW'($urandom);
            end else if (hostActive && $urandom_range(0, 99) < 3) begin
                hostActive = 0;
            end
            applyStimulus($urandom_range(0, 99) < 80, AW'($urandom), DW'($urandom), hostActive, hA, hD);
            if (hostGranted) hostActive = 0;
        end
        idleCycles(3);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_write_arbiter.md
Name: data_ram_write_arbiter

Overview:
- Shares the single write port of the MiniAlu data RAM (the dual-read-port RAM) between two requesters: ALU writeback and a host/debug loader.
- ALU writes have priority. A starvation counter forces a host grant after MAX_WAIT blocked cycles, and stalls the ALU (IP counter and decode FFDs) for that one cycle.
- Sits between the MiniAlu execute stage and the RAM write port; all RAM write signals leave the block registered.

Parameters:
DATA_WIDTH, 16, width of write data (matches RAM word)
ADDR_WIDTH, 4, width of RAM write address
MAX_WAIT, 4, blocked host cycles before a forced grant; legal range 1..15

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
iAluWe  in  1  ALU writeback request for the current cycle
iAluAddr  in  ADDR_WIDTH  ALU write address
iAluData  in  DATA_WIDTH  ALU write data
oAluStall  out  1  combinational; ALU must hold IP and decode registers this cycle and re-present its write
iHostReq  in  1  host write request (level, held until ack)
iHostAddr  in  ADDR_WIDTH  host write address, stable while iHostReq=1
iHostData  in  DATA_WIDTH  host write data, stable while iHostReq=1
oHostAck  out  1  registered one-cycle pulse: host write accepted
oRamWe  out  1  registered RAM write enable
oRamAddr  out  ADDR_WIDTH  registered RAM write address
oRamData  out  DATA_WIDTH  registered RAM write data
oForcedCnt  out  8  registered count of forced grants, saturating at 255

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, wait counter=0, oRamWe=0, oRamAddr=0, oRamData=0, oHostAck=0, oForcedCnt=0. oAluStall=0 because it is decoded from IDLE. Release is sampled on the first rising edge with Reset=1.
- Latency: every accepted write appears on oRam* exactly 1 cycle after acceptance. oHostAck rises on the same edge as the host's oRamWe.
- Only one write is accepted per cycle. When no write is accepted: oRamWe=0, and oRamAddr/oRamData hold their previous values.
- State IDLE:
  - iHostReq=1 and iAluWe=0: accept the host write; go to ACK.
  - iHostReq=1 and iAluWe=1: accept the ALU write; wait counter=1; go to WAIT.
  - iHostReq=0: accept the ALU write if iAluWe=1; stay in IDLE.
- State WAIT:
  - iAluWe=0: accept the host write; counter=0; go to ACK.
  - iAluWe=1 and counter<MAX_WAIT: accept the ALU write; counter+1; stay in WAIT.
  - iAluWe=1 and counter==MAX_WAIT: oAluStall=1 this cycle; accept the host write and drop the ALU write (the ALU re-presents it next cycle); oForcedCnt+1 (saturating); counter=0; go to ACK.
  - iHostReq=0 (protocol violation): counter=0; go to IDLE; the ALU write, if any, is accepted normally.
- State ACK (lasts 1 cycle):
  - oHostAck=1; iHostReq is ignored this cycle.
  - An ALU write is accepted normally; oAluStall=0.
  - Always return to IDLE.
  - Minimum spacing between host writes is therefore 2 cycles.
- oAluStall is asserted only in WAIT with counter==MAX_WAIT and iAluWe=1; it is never asserted in IDLE or ACK.
- Maximum host latency from request to ack: MAX_WAIT+2 cycles.
- The host must drop iHostReq in the cycle after the ack, or the request is treated as a new one.
- Same address written by both requesters in consecutive cycles: the later accepted write wins; no merging.
- Counter width is 4 bits; MAX_WAIT=0 is unsupported.
- Reset asserted mid-transaction: a pending host request is discarded and no ack is issued. The host re-requests after reset release.

Test Plan:
- Reset: drive Reset=0 with random inputs toggling. All registered outputs read 0 and oAluStall=0. Release Reset; the first ALU write (addr 3, data 0x1234) appears as oRamWe=1, oRamAddr=3, oRamData=0x1234 one cycle later.
- Free-slot host write: iAluWe=0; host req addr 5, data 0xBEEF. Next cycle: oRamWe=1, oRamAddr=5, oRamData=0xBEEF, oHostAck=1. oAluStall stays 0 throughout.
- Forced grant, MAX_WAIT=4: iAluWe=1 continuously with ALU data 0x0001..; host req addr 7, data 0x00AA.
  - The first 4 cycles write ALU data.
  - In the 5th cycle oAluStall=1 and the RAM then receives addr 7, data 0x00AA with oHostAck=1.
  - The stalled ALU write lands the following cycle; oForcedCnt=1.
- Back-to-back host: host holds iHostReq high continuously with iAluWe=0. Acks occur every 2nd cycle, never on consecutive cycles.
- Host abort: host req during ALU writes, dropped after 2 WAIT cycles. The block returns to IDLE, issues no ack, and a later request starts counting from 1 again.
- Reset mid-WAIT: assert Reset at counter=3. On release no ack is issued and oForcedCnt=0.
